hex_key_capture: RTL



---
 rtl/hex_keypad_pkg.sv | 13 +
 rtl/key_fifo.sv | 69 ++++++
 rtl/hex_key_capture.sv | 92 +++++++++
 3 files changed

// File: rtl/hex_keypad_pkg.sv
// rtl/hex_keypad_pkg.sv - shared types and constants for the hex keypad capture path
package hex_keypad_pkg;

    localparam int KEY_CODE_W = 4;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    typedef enum logic {
        FLT_READY   = 1'b0,
        FLT_HOLDOFF = 1'b1
    } flt_state_t;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - DEPTH x 4 first-word fall-through key code FIFO
module key_fifo
    import hex_keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  key_code_t                push_data,
    input  logic                     pop,
    output key_code_t                head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    key_code_t              mem_q   [DEPTH];
    key_code_t              mem_d   [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic                   do_push;
    logic                   do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    // Head reads as zero when empty so stale entries never leak out.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hex_key_capture.sv
// rtl/hex_key_capture.sv - keypad code capture with repeat hold-off, FIFO and overflow flag
module hex_key_capture
    import hex_keypad_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [KEY_CODE_W-1:0]    code_in,
    input  logic                     valid_in,
    output logic [KEY_CODE_W-1:0]    key_data,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int TIMER_W = $clog2(HOLDOFF + 1);

    flt_state_t             state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    key_code_t              last_code_q, last_code_d;
    logic                   overflow_q, overflow_d;
    logic                   accept;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign key_valid = !fifo_empty;
    assign fifo_pop  = key_valid && key_ready;
    assign overflow  = overflow_q;

    // Filter, timer and overflow registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= FLT_READY;
            timer_q     <= '0;
            last_code_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_code_q <= last_code_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next filter state and hold-off timer; a new accept always restarts the window.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        last_code_d = last_code_q;
        if (accept) begin
            state_d     = FLT_HOLDOFF;
            timer_d     = TIMER_W'(HOLDOFF);
            last_code_d = code_in;
        end else if (state_q == FLT_HOLDOFF) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) begin
                state_d = FLT_READY;
            end
        end
    end

    // Accept decision and overflow update; a lost key outranks clear_ovf.
    always_comb begin
        accept = valid_in && ((state_q == FLT_READY) || (code_in != last_code_q));
        overflow_d = overflow_q;
        if (accept && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    key_fifo #(
        .DEPTH(DEPTH)
    ) u_key_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (code_in),
        .pop       (fifo_pop),
        .head_data (key_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
